// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Fetch-stage controller for the 8-bit processor. Owns the program counter,
// addresses a combinational-read 256 x 14 instruction ROM, captures each
// returned word into an instruction register and presents it to decode.
// Handles start, stall, branch redirect/flush, halt detection and PC wrap.
//
// Handshake to decode: a word transfers on any rising edge where
// if_valid && if_ready are both high. While if_valid is high and if_ready is
// low, if_instruction / if_pc / current_pc are held stable. A redirect flushes
// the register (if_valid drops) even if the held word was never accepted.
//
// Ports:
//   clk              single clock, rising edge
//   rst_n            asynchronous active-low reset
//   start            begin/restart fetching at RESET_PC (IDLE/HALT only)
//   current_pc       registered ROM address
//   rom_instruction  ROM data at current_pc, same cycle
//   if_instruction   instruction register to decode
//   if_pc            address the held instruction was fetched from
//   if_valid         instruction register holds a live instruction
//   if_ready         decode accepts the held instruction
//   redirect_valid   taken branch/jump: flush and reload PC
//   redirect_pc      redirect target
//   halted           high while in HALT
//   pc_wrap          one-cycle pulse after the PC steps 8'hFF -> 8'h00
//   dbg_state        current FSM state (0 IDLE, 1 RUN, 2 HALT)
module fetch_sequencer #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [13:0] HALT_WORD = 14'h3FFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  current_pc,
  input  logic [13:0] rom_instruction,
  output logic [13:0] if_instruction,
  output logic [7:0]  if_pc,
  output logic        if_valid,
  input  logic        if_ready,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        halted,
  output logic        pc_wrap,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [7:0]  pc_d;
  logic [13:0] ir_d;
  logic [7:0]  if_pc_d;
  logic        valid_d;
  logic        wrap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      current_pc     <= RESET_PC;
      if_instruction <= 14'h0000;
      if_pc          <= 8'h00;
      if_valid       <= 1'b0;
      pc_wrap        <= 1'b0;
    end else begin
      state          <= state_d;
      current_pc     <= pc_d;
      if_instruction <= ir_d;
      if_pc          <= if_pc_d;
      if_valid       <= valid_d;
      pc_wrap        <= wrap_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = current_pc;
    ir_d    = if_instruction;
    if_pc_d = if_pc;
    valid_d = if_valid;
    wrap_d  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (redirect_valid) begin
          // Flush wins over capture; a concurrent accept still completes
          // on the decode side since it sampled if_valid && if_ready.
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (!if_valid || if_ready) begin
          ir_d    = rom_instruction;
          if_pc_d = current_pc;
          valid_d = 1'b1;
          if (rom_instruction == HALT_WORD) begin
            // PC parks on the halt word's address.
            state_d = S_HALT;
          end else begin
            pc_d   = current_pc + 8'd1;
            wrap_d = (current_pc == 8'hFF);
          end
        end
      end

      S_HALT: begin
        if (if_valid && if_ready) begin
          valid_d = 1'b0;
        end
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = S_RUN;
        end else if (start) begin
          pc_d    = RESET_PC;
          valid_d = 1'b0;
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Decoded from the state register so it tracks reset asynchronously.
  assign halted    = (state == S_HALT);
  assign dbg_state = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam logic [13:0] HALT_W = 14'h3FFF;
  localparam int MODE_IDLE = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_HALT = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  current_pc;
  logic [13:0] rom_instruction;
  logic [13:0] if_instruction;
  logic [7:0]  if_pc;
  logic        if_valid;
  logic        if_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halted;
  logic        pc_wrap;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  logic [13:0] rom [256];
  assign rom_instruction = rom[current_pc];

  fetch_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .current_pc      (current_pc),
    .rom_instruction (rom_instruction),
    .if_instruction  (if_instruction),
    .if_pc           (if_pc),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halted          (halted),
    .pc_wrap         (pc_wrap),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_compared   = 0;
  int n_mismatched = 0;
  logic [13:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Behaviour written straight from the fetch rules: a mode, a PC as an
  // integer that wraps modulo 256, and the held instruction.
  int          m_mode;
  int          m_pc;
  logic [13:0] m_ir;
  int          m_ifpc;
  bit          m_valid;
  bit          m_wrap;

  task automatic model_reset();
    m_mode  = MODE_IDLE;
    m_pc    = 0;
    m_ir    = 14'h0000;
    m_ifpc  = 0;
    m_valid = 1'b0;
    m_wrap  = 1'b0;
    exp_q.delete();
  endtask

  always @(posedge clk) begin : model_step
    logic [13:0] w;
    if (rst_n) begin
      m_wrap = 1'b0;
      if (m_mode == MODE_IDLE) begin
        if (start) begin
          m_pc   = 0;
          m_mode = MODE_RUN;
        end
      end else if (m_mode == MODE_RUN) begin
        if (redirect_valid) begin
          m_pc    = int'(redirect_pc);
          m_valid = 1'b0;
          exp_q.delete();
        end else if (!m_valid || if_ready) begin
          w       = rom[m_pc];
          m_ir    = w;
          m_ifpc  = m_pc;
          m_valid = 1'b1;
          exp_q.push_back(w);
          if (w == HALT_W) begin
            m_mode = MODE_HALT;
          end else begin
            m_wrap = (m_pc == 255);
            m_pc   = (m_pc + 1) % 256;
          end
        end
      end else begin
        if (m_valid && if_ready) m_valid = 1'b0;
        if (redirect_valid) begin
          m_pc    = int'(redirect_pc);
          m_valid = 1'b0;
          m_mode  = MODE_RUN;
          exp_q.delete();
        end else if (start) begin
          m_pc    = 0;
          m_valid = 1'b0;
          m_mode  = MODE_RUN;
          exp_q.delete();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Advance one clock; check accepted words against the queue and every
  // output against the model, #1 after the edge.
  task automatic tick();
    if (rst_n && if_valid && if_ready) begin
      if (exp_q.size() == 0) check_eq("accept_unexpected", 32'(if_valid), 32'd0);
      else                   check_eq("accept_word", 32'(if_instruction), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    check_eq("current_pc", 32'(current_pc), 32'(m_pc));
    check_eq("if_valid", 32'(if_valid), 32'(m_valid));
    check_eq("if_instruction", 32'(if_instruction), 32'(m_ir));
    check_eq("if_pc", 32'(if_pc), 32'(m_ifpc));
    check_eq("halted", 32'(halted), 32'(m_mode == MODE_HALT));
    check_eq("pc_wrap", 32'(pc_wrap), 32'(m_wrap));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_pc"}, 32'(current_pc), 32'h00);
    check_eq({tag, "_ir"}, 32'(if_instruction), 32'h0000);
    check_eq({tag, "_ifpc"}, 32'(if_pc), 32'h00);
    check_eq({tag, "_valid"}, 32'(if_valid), 32'd0);
    check_eq({tag, "_halted"}, 32'(halted), 32'd0);
    check_eq({tag, "_wrap"}, 32'(pc_wrap), 32'd0);
  endtask

  // Assert reset between edges, check it takes effect at once, release on
  // a falling edge.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 14'($urandom_range(0, 14'h3FFE));
    rom[0] = 14'h0101; rom[1] = 14'h0202; rom[2] = 14'h0303; rom[3] = HALT_W;
    rom[8'h40] = 14'h1234;
    model_reset();
    #2;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores redirect
    redirect_valid = 1'b1; redirect_pc = 8'h55;
    tick(); tick();
    check_eq("idle_pc", 32'(current_pc), 32'h00);
    check_eq("idle_valid", 32'(if_valid), 32'd0);
    redirect_valid = 1'b0;

    // start, straight run to halt
    start = 1'b1; if_ready = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_pc", 32'(current_pc), 32'h00);
    check_eq("start_valid", 32'(if_valid), 32'd0);
    tick();
    check_eq("run_ir0", 32'(if_instruction), 32'h0101); check_eq("run_pc0", 32'(if_pc), 32'h00);
    tick();
    check_eq("run_ir1", 32'(if_instruction), 32'h0202); check_eq("run_pc1", 32'(if_pc), 32'h01);
    tick();
    check_eq("run_ir2", 32'(if_instruction), 32'h0303); check_eq("run_pc2", 32'(if_pc), 32'h02);
    tick();
    check_eq("run_ir3", 32'(if_instruction), 32'h3FFF); check_eq("run_pc3", 32'(if_pc), 32'h03);
    check_eq("halt_flag", 32'(halted), 32'd1); check_eq("halt_pc", 32'(current_pc), 32'h03);
    check_eq("halt_word_valid", 32'(if_valid), 32'd1);
    tick();
    check_eq("halt_accepted", 32'(if_valid), 32'd0);
    tick();
    check_eq("halt_no_capture", 32'(if_instruction), 32'h3FFF);
    check_eq("halt_hold_pc", 32'(current_pc), 32'h03);

    // exit HALT with start, then stall
    start = 1'b1; if_ready = 1'b0;
    tick();
    start = 1'b0;
    check_eq("restart_pc", 32'(current_pc), 32'h00);
    check_eq("restart_halted", 32'(halted), 32'd0);
    tick();
    check_eq("stall_first_ir", 32'(if_instruction), 32'h0101);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_ir", 32'(if_instruction), 32'h0101);
      check_eq("stall_ifpc", 32'(if_pc), 32'h00);
      check_eq("stall_pc", 32'(current_pc), 32'h01);
    end
    if_ready = 1'b1;
    tick();
    check_eq("release_ir", 32'(if_instruction), 32'h0202);
    check_eq("release_ifpc", 32'(if_pc), 32'h01);

    // redirect flushes an un-accepted instruction
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    check_eq("redir_flush", 32'(if_valid), 32'd0);
    check_eq("redir_pc", 32'(current_pc), 32'h40);
    tick();
    check_eq("redir_ir", 32'(if_instruction), 32'h1234);
    check_eq("redir_ifpc", 32'(if_pc), 32'h40);

    // wrap FE, FF, 00
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    check_eq("wrap_redirect_nopulse", 32'(pc_wrap), 32'd0);
    tick();
    check_eq("wrap_fe", 32'(if_pc), 32'hFE); check_eq("wrap_fe_pulse", 32'(pc_wrap), 32'd0);
    tick();
    check_eq("wrap_ff", 32'(if_pc), 32'hFF); check_eq("wrap_pc00", 32'(current_pc), 32'h00);
    check_eq("wrap_pulse", 32'(pc_wrap), 32'd1);
    tick();
    check_eq("wrap_00", 32'(if_pc), 32'h00); check_eq("wrap_pulse_end", 32'(pc_wrap), 32'd0);
    for (int i = 0; i < 20 && !halted; i++) tick();
    check_eq("halt_reached", 32'(halted), 32'd1);

    // exit HALT via redirect; redirect beats a simultaneous start
    redirect_valid = 1'b1; redirect_pc = 8'h10; start = 1'b1;
    tick();
    redirect_valid = 1'b0; start = 1'b0;
    check_eq("hredir_pc", 32'(current_pc), 32'h10);
    check_eq("hredir_halted", 32'(halted), 32'd0);
    tick();
    check_eq("hredir_ifpc", 32'(if_pc), 32'h10);
    check_eq("hredir_ir", 32'(if_instruction), 32'(rom[8'h10]));
    tick();

    // async reset mid-run, then stays IDLE until start
    async_reset("midrun_reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("post_reset_idle_valid", 32'(if_valid), 32'd0);
      check_eq("post_reset_idle_pc", 32'(current_pc), 32'h00);
    end

    // randomized traffic with a few extra halt words
    for (int i = 0; i < 6; i++) rom[$urandom_range(4, 255)] = HALT_W;
    for (int c = 0; c < 600; c++) begin
      if_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hFC, 8'hFF))
                                                   : 8'($urandom);
      start          = ($urandom_range(0, 14) == 0);
      if (c == 300) async_reset("random_reset");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
